// File: rtl/odd_sequence_checker.sv
// odd_sequence_checker
// Monitors an odd-count stream (1,3,5,...,2^WIDTH-1,1,...) and verifies it.
// Acquires lock after LOCK_CNT consecutive matching samples and flags parity
// and sequence errors. It also keeps a saturating tally of sequence errors.
//
// Optional feature, enabled by defining ODD_CHECK_RESTART_TOLERANT_EN:
//   in LOCKED, a valid sample of 1 while the checker expects something else
//   is accepted as a counter restart instead of being flagged as an error.
//
// Handshake: count_in is qualified by count_valid alone. There is no
// back-pressure. A sample is consumed on every rising edge where count_valid
// is high. When count_valid is low, all state holds and every pulse output
// reads 0.
//
// All outputs are registered and reflect the sample from the previous edge.

module odd_sequence_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic             parity_err,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]       LOCK_N  = 4'(LOCK_CNT);
    localparam logic [WIDTH-1:0] MAX_ODD = {WIDTH{1'b1}};

    state_t           state;
    logic [3:0]       match_cnt;
    logic [WIDTH-1:0] next_val;
    logic             sample_odd;
    logic             sample_match;

    // Sample + 2 truncated to WIDTH; the top-odd to 1 wrap happens naturally.
    assign next_val     = count_in + WIDTH'(2);
    assign sample_odd   = count_in[0];
    assign sample_match = (count_in == expected);
    assign state_dbg    = state;

    // Lock-acquisition FSM with registered status, pulse and tally outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            match_cnt  <= 4'd0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            parity_err <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
            expected   <= '0;
        end else begin
            err_pulse  <= 1'b0;
            parity_err <= 1'b0;
            wrap_pulse <= 1'b0;
            if (count_valid) begin
                case (state)
                    HUNT: begin
                        if (sample_odd) begin
                            expected  <= next_val;
                            match_cnt <= 4'd1;
                            if (LOCK_CNT == 1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state <= VERIFY;
                            end
                        end else begin
                            parity_err <= 1'b1;
                        end
                    end

                    VERIFY: begin
                        if (!sample_odd) begin
                            parity_err <= 1'b1;
                            state      <= HUNT;
                            expected   <= '0;
                            match_cnt  <= 4'd0;
                        end else if (sample_match) begin
                            expected  <= next_val;
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == LOCK_N) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            // An odd mismatch before lock reseeds silently.
                            expected  <= next_val;
                            match_cnt <= 4'd1;
                        end
                    end

                    LOCKED: begin
                        if (sample_match) begin
                            expected <= next_val;
                            if (count_in == MAX_ODD) begin
                                wrap_pulse <= 1'b1;
                            end
`ifdef ODD_CHECK_RESTART_TOLERANT_EN
                        end else if (count_in == WIDTH'(1)) begin
                            // Counter restarted from 1: stay locked, expect 3.
                            expected <= WIDTH'(3);
`endif
                        end else begin
                            err_pulse <= 1'b1;
                            if (err_count != {ERR_W{1'b1}}) begin
                                err_count <= err_count + ERR_W'(1);
                            end
                            if (sample_odd) begin
                                expected  <= next_val;
                                match_cnt <= 4'd1;
                                if (LOCK_CNT == 1) begin
                                    state  <= LOCKED;
                                    locked <= 1'b1;
                                end else begin
                                    state  <= VERIFY;
                                    locked <= 1'b0;
                                end
                            end else begin
                                parity_err <= 1'b1;
                                state      <= HUNT;
                                locked     <= 1'b0;
                                expected   <= '0;
                                match_cnt  <= 4'd0;
                            end
                        end
                    end

                    default: begin
                        state     <= HUNT;
                        locked    <= 1'b0;
                        expected  <= '0;
                        match_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_odd_sequence_checker.sv
// Testbench for odd_sequence_checker (WIDTH=4, LOCK_CNT=2, ERR_W=8).
// Table of hand-derived vectors, hand sequences for saturation/reset/hold,
// then randomized traffic checked against a run-length reference model.

module tb_odd_sequence_checker;

    localparam int W  = 4;
    localparam int LC = 2;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  count_in;
    logic          count_valid;
    logic          locked;
    logic          err_pulse;
    logic          parity_err;
    logic          wrap_pulse;
    logic [EW-1:0] err_count;
    logic [W-1:0]  expected;
    logic [1:0]    state_dbg;

    int checks   = 0;
    int failures = 0;

    odd_sequence_checker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(EW)) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .count_valid(count_valid),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .parity_err (parity_err),
        .wrap_pulse (wrap_pulse),
        .err_count  (err_count),
        .expected   (expected),
        .state_dbg  (state_dbg)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Reference model: remembers the last accepted odd value and the length of
    // the current run of consecutive matches; lock means run >= LC.
    bit            m_seed;
    logic [W-1:0]  m_last;
    int            m_run;
    logic [EW-1:0] m_ec;
    bit            m_err, m_par, m_wrap;

    function automatic bit m_locked();
        return m_run >= LC;
    endfunction

    function automatic logic [W-1:0] m_exp();
        logic [W-1:0] e;
        e = m_last + 4'd2;
        return m_seed ? e : 4'd0;
    endfunction

    task automatic model_step(input bit r, input bit v, input logic [W-1:0] s);
        bit           was_locked;
        logic [W-1:0] nxt;
        m_err  = 0;
        m_par  = 0;
        m_wrap = 0;
        if (r) begin
            m_seed = 0;
            m_run  = 0;
            m_last = '0;
            m_ec   = '0;
        end else if (v) begin
            was_locked = m_locked();
            nxt        = m_last + 4'd2;
            if (!s[0]) begin
                m_par = 1;
                if (was_locked) m_err = 1;
                m_seed = 0;
                m_run  = 0;
            end else if (!m_seed) begin
                m_seed = 1;
                m_last = s;
                m_run  = 1;
            end else if (s == nxt) begin
                m_last = s;
                if (m_run < LC) m_run++;
                if (was_locked && s == 4'd15) m_wrap = 1;
`ifdef ODD_CHECK_RESTART_TOLERANT_EN
            end else if (was_locked && s == 4'd1) begin
                m_last = 4'd1;
`endif
            end else begin
                if (was_locked) m_err = 1;
                m_last = s;
                m_run  = 1;
            end
            if (m_err && m_ec != 8'hFF) m_ec++;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle (inputs change at negedge), then sample at the next negedge.
    task automatic apply(input bit r, input bit v, input logic [W-1:0] s);
        reset       = r;
        count_valid = v;
        count_in    = s;
        @(posedge clk);
        model_step(r, v, s);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_locked"},     32'(locked),     32'(m_locked()));
        chk({tag, "_err_pulse"},  32'(err_pulse),  32'(m_err));
        chk({tag, "_parity_err"}, 32'(parity_err), 32'(m_par));
        chk({tag, "_wrap_pulse"}, 32'(wrap_pulse), 32'(m_wrap));
        chk({tag, "_err_count"},  32'(err_count),  32'(m_ec));
        chk({tag, "_expected"},   32'(expected),   32'(m_exp()));
    endtask

    typedef struct {
        bit           rst;
        bit           v;
        logic [W-1:0] in;
        bit           lk;
        bit           er;
        bit           pa;
        bit           wr;
        logic [EW-1:0] ec;
        logic [W-1:0] ex;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl[NV];

    // Stimulus and checking.
    initial begin
        logic [W-1:0] e, bad, val;
        bit           r, v;

        reset       = 1'b1;
        count_valid = 1'b0;
        count_in    = '0;
        m_seed = 0; m_run = 0; m_last = '0; m_ec = '0;
        m_err = 0; m_par = 0; m_wrap = 0;

        //            rst v  in   lk er pa wr ec ex
        tbl[0]  = '{1, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0,   0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, 1,   0, 0, 0, 0, 0, 3};
        tbl[3]  = '{0, 1, 3,   1, 0, 0, 0, 0, 5};
        tbl[4]  = '{0, 1, 5,   1, 0, 0, 0, 0, 7};
        tbl[5]  = '{0, 1, 7,   1, 0, 0, 0, 0, 9};
        tbl[6]  = '{0, 1, 9,   1, 0, 0, 0, 0, 11};
        tbl[7]  = '{0, 1, 11,  1, 0, 0, 0, 0, 13};
        tbl[8]  = '{0, 1, 13,  1, 0, 0, 0, 0, 15};
        tbl[9]  = '{0, 1, 15,  1, 0, 0, 1, 0, 1};
        tbl[10] = '{0, 1, 1,   1, 0, 0, 0, 0, 3};
        tbl[11] = '{0, 1, 3,   1, 0, 0, 0, 0, 5};
        tbl[12] = '{0, 1, 5,   1, 0, 0, 0, 0, 7};
        tbl[13] = '{0, 1, 9,   0, 1, 0, 0, 1, 11};
        tbl[14] = '{0, 1, 11,  1, 0, 0, 0, 1, 13};
        tbl[15] = '{0, 1, 4,   0, 1, 1, 0, 2, 0};
        tbl[16] = '{0, 1, 2,   0, 0, 1, 0, 2, 0};
        tbl[17] = '{0, 0, 7,   0, 0, 0, 0, 2, 0};
        tbl[18] = '{0, 1, 5,   0, 0, 0, 0, 2, 7};
        tbl[19] = '{0, 1, 7,   1, 0, 0, 0, 2, 9};
`ifdef ODD_CHECK_RESTART_TOLERANT_EN
        tbl[20] = '{0, 1, 1,   1, 0, 0, 0, 2, 3};
`else
        tbl[20] = '{0, 1, 1,   0, 1, 0, 0, 3, 3};
`endif

        @(negedge clk);

        // Table-driven directed vectors.
        for (int i = 0; i < NV; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply(tbl[i].rst, tbl[i].v, tbl[i].in);
            chk({tag, "_locked"},     32'(locked),     32'(tbl[i].lk));
            chk({tag, "_err_pulse"},  32'(err_pulse),  32'(tbl[i].er));
            chk({tag, "_parity_err"}, 32'(parity_err), 32'(tbl[i].pa));
            chk({tag, "_wrap_pulse"}, 32'(wrap_pulse), 32'(tbl[i].wr));
            chk({tag, "_err_count"},  32'(err_count),  32'(tbl[i].ec));
            chk({tag, "_expected"},   32'(expected),   32'(tbl[i].ex));
        end

        // Re-establish lock at expected 5.
        apply(0, 1, 4'd1);
        apply(0, 1, 4'd3);
        chk("relock_locked", 32'(locked), 32'd1);
        chk("relock_expected", 32'(expected), 32'd5);

        // 300 forced sequence errors: odd mismatch, then one match to relock.
        for (int i = 0; i < 300; i++) begin
            e   = m_exp();
            bad = e + 4'd4;
            if (bad == 4'd1) bad = e + 4'd6;
            apply(0, 1, bad);
            check_model("sat_err");
            apply(0, 1, m_exp());
            check_model("sat_relock");
        end
        chk("sat_err_count", 32'(err_count), 32'd255);

        // One more error at saturation still pulses but the tally stays.
        apply(0, 1, 4'd6);
        chk("sat_hold_pulse", 32'(err_pulse), 32'd1);
        chk("sat_hold_count", 32'(err_count), 32'd255);

        // Reset mid-stream with count_valid high wins.
        apply(0, 1, 4'd1);
        apply(0, 1, 4'd3);
        apply(1, 1, 4'd5);
        chk("rst_mid_locked", 32'(locked), 32'd0);
        chk("rst_mid_err_count", 32'(err_count), 32'd0);
        chk("rst_mid_expected", 32'(expected), 32'd0);
        chk("rst_mid_pulses", 32'({err_pulse, parity_err, wrap_pulse}), 32'd0);

        // count_valid low for 5 cycles freezes everything.
        apply(0, 1, 4'd1);
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 4'($urandom_range(0, 15)));
            chk("hold_expected", 32'(expected), 32'd3);
            chk("hold_locked", 32'(locked), 32'd0);
            chk("hold_pulses", 32'({err_pulse, parity_err, wrap_pulse}), 32'd0);
            chk("hold_err_count", 32'(err_count), 32'd0);
        end
        apply(0, 1, 4'd3);
        chk("hold_resume_locked", 32'(locked), 32'd1);
        chk("hold_resume_expected", 32'(expected), 32'd5);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 99) < 85);
            if (m_seed && $urandom_range(0, 99) < 75) val = m_exp();
            else if ($urandom_range(0, 9) == 0) val = 4'd1;
            else val = 4'($urandom_range(0, 15));
            apply(r, v, val);
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
